// File: rtl/bp_io_cmd_arbiter.sv
// Round-robin arbiter that funnels requester commands onto one IO link
// and routes in-order link responses back to the issuing requester.
module bp_io_cmd_arbiter #(
   parameter int num_req_p         = 2,
   parameter int msg_width_p       = 128,
   parameter int max_outstanding_p = 4,
   localparam int cnt_w = $clog2(max_outstanding_p + 1)
) (
   input  logic                             clk_i,
   input  logic                             reset_i,
   input  logic [num_req_p*msg_width_p-1:0] cmd_i,
   input  logic [num_req_p-1:0]             cmd_v_i,
   output logic [num_req_p-1:0]             cmd_ready_o,
   output logic [msg_width_p-1:0]           resp_o,
   output logic [num_req_p-1:0]             resp_v_o,
   input  logic [num_req_p-1:0]             resp_yumi_i,
   output logic [msg_width_p-1:0]           io_cmd_o,
   output logic                             io_cmd_v_o,
   input  logic                             io_cmd_ready_i,
   input  logic [msg_width_p-1:0]           io_resp_i,
   input  logic                             io_resp_v_i,
   output logic                             io_resp_yumi_o,
   output logic [cnt_w-1:0]                 outstanding_o,
   output logic                             error_o
);

   localparam int id_w = $clog2(num_req_p);
   localparam int aw   = (max_outstanding_p > 1) ? $clog2(max_outstanding_p) : 1;

   logic [id_w-1:0]  ptr_r;
   logic             lock_v_r;
   logic [id_w-1:0]  lock_id_r;
   logic [id_w-1:0]  id_mem [max_outstanding_p];
   logic [aw-1:0]    wr_ptr_r;
   logic [aw-1:0]    rd_ptr_r;
   logic [cnt_w-1:0] count_r;
   logic             error_r;

   logic [id_w-1:0]  scan_id;
   logic [id_w-1:0]  winner;
   logic [id_w-1:0]  head;
   logic             credit;
   logic             empty;
   logic             push;
   logic             pop;

   always_comb begin
      scan_id = ptr_r;
      for (int i = num_req_p - 1; i >= 0; i--) begin
         int k;
         k = int'(ptr_r) + i;
         if (k >= num_req_p) k = k - num_req_p;
         // Walking downward lets the nearest valid requester win last.
         if (cmd_v_i[k]) scan_id = id_w'(k);
      end
   end

   assign winner = lock_v_r ? lock_id_r : scan_id;
   assign credit = count_r < cnt_w'(max_outstanding_p);
   assign empty  = (count_r == '0);
   assign head   = id_mem[rd_ptr_r];

   assign io_cmd_v_o = !reset_i && (|cmd_v_i) && credit;
   assign io_cmd_o   = cmd_i[winner*msg_width_p +: msg_width_p];
   assign push       = io_cmd_v_o && io_cmd_ready_i;

   always_comb begin
      cmd_ready_o = '0;
      if (!reset_i && io_cmd_ready_i && credit) cmd_ready_o[winner] = 1'b1;
   end

   always_comb begin
      resp_v_o = '0;
      if (!reset_i && !empty) resp_v_o[head] = io_resp_v_i;
   end

   assign resp_o         = io_resp_i;
   assign io_resp_yumi_o = !reset_i && !empty && io_resp_v_i && resp_yumi_i[head];
   assign pop            = io_resp_yumi_o;
   assign outstanding_o  = count_r;
   assign error_o        = error_r;

   always_ff @(posedge clk_i or posedge reset_i) begin
      if (reset_i) begin
         ptr_r     <= '0;
         lock_v_r  <= 1'b0;
         lock_id_r <= '0;
      end else if (push) begin
         ptr_r    <= (winner == id_w'(num_req_p - 1)) ? '0 : winner + 1'b1;
         lock_v_r <= 1'b0;
      end else if (io_cmd_v_o) begin
         lock_v_r  <= 1'b1;
         lock_id_r <= winner;
      end
   end

   always_ff @(posedge clk_i) begin
      if (push) id_mem[wr_ptr_r] <= winner;
   end

   always_ff @(posedge clk_i or posedge reset_i) begin
      if (reset_i) begin
         wr_ptr_r <= '0;
         rd_ptr_r <= '0;
         count_r  <= '0;
      end else begin
         if (push)
            wr_ptr_r <= (wr_ptr_r == aw'(max_outstanding_p - 1)) ? '0 : wr_ptr_r + 1'b1;
         if (pop)
            rd_ptr_r <= (rd_ptr_r == aw'(max_outstanding_p - 1)) ? '0 : rd_ptr_r + 1'b1;
         unique case ({push, pop})
            2'b10:   count_r <= count_r + 1'b1;
            2'b01:   count_r <= count_r - 1'b1;
            default: count_r <= count_r;
         endcase
      end
   end

   always_ff @(posedge clk_i or posedge reset_i) begin
      if (reset_i) error_r <= 1'b0;
      else if (io_resp_v_i && empty) error_r <= 1'b1;
   end

endmodule

// File: tb/tb_bp_io_cmd_arbiter.sv
// Directed bench for bp_io_cmd_arbiter: arbitration, lock, credit,
// response routing and spurious-response error.
module tb_bp_io_cmd_arbiter;

   localparam int nr = 2;
   localparam int mw = 128;
   localparam int mo = 4;

   logic            clk = 1'b0;
   logic            reset;
   logic [nr*mw-1:0] cmd;
   logic [nr-1:0]   cmd_v;
   logic [nr-1:0]   cmd_ready;
   logic [mw-1:0]   resp;
   logic [nr-1:0]   resp_v;
   logic [nr-1:0]   resp_yumi;
   logic [mw-1:0]   io_cmd;
   logic            io_cmd_v;
   logic            io_cmd_ready;
   logic [mw-1:0]   io_resp;
   logic            io_resp_v;
   logic            io_resp_yumi;
   logic [2:0]      outstanding;
   logic            error;

   int checks = 0;
   int errors = 0;

   logic [mw-1:0] msg0;
   logic [mw-1:0] msg1;
   logic [mw-1:0] rmsg;

   always #5 clk = ~clk;

   bp_io_cmd_arbiter #(
      .num_req_p(nr), .msg_width_p(mw), .max_outstanding_p(mo)
   ) dut (
      .clk_i(clk), .reset_i(reset),
      .cmd_i(cmd), .cmd_v_i(cmd_v), .cmd_ready_o(cmd_ready),
      .resp_o(resp), .resp_v_o(resp_v), .resp_yumi_i(resp_yumi),
      .io_cmd_o(io_cmd), .io_cmd_v_o(io_cmd_v), .io_cmd_ready_i(io_cmd_ready),
      .io_resp_i(io_resp), .io_resp_v_i(io_resp_v), .io_resp_yumi_o(io_resp_yumi),
      .outstanding_o(outstanding), .error_o(error)
   );

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic idle_inputs();
      cmd_v        = '0;
      io_cmd_ready = 1'b0;
      io_resp_v    = 1'b0;
      resp_yumi    = '0;
   endtask

   task automatic do_reset();
      idle_inputs();
      reset = 1'b1;
      tick();
      tick();
      reset = 1'b0;
      #1;
   endtask

   task automatic test_reset();
      reset        = 1'b1;
      cmd_v        = 2'b11;
      io_cmd_ready = 1'b1;
      io_resp_v    = 1'b1;
      resp_yumi    = 2'b11;
      tick();
      #1;
      checks++;
      if (io_cmd_v !== 1'b0 || cmd_ready !== 2'b00) begin
         errors++;
         $display("FAIL reset_cmd: io_cmd_v=%b cmd_ready=%b, want 0/00", io_cmd_v, cmd_ready);
      end
      checks++;
      if (resp_v !== 2'b00 || io_resp_yumi !== 1'b0) begin
         errors++;
         $display("FAIL reset_resp: resp_v=%b yumi=%b, want 00/0", resp_v, io_resp_yumi);
      end
      checks++;
      if (outstanding !== 3'd0 || error !== 1'b0) begin
         errors++;
         $display("FAIL reset_state: outstanding=%0d error=%b, want 0/0", outstanding, error);
      end
      do_reset();
   endtask

   task automatic test_fairness();
      logic [1:0] exp_rdy;
      logic [1:0] exp_rv;
      do_reset();
      cmd_v     = 2'b11;
      resp_yumi = 2'b11;
      for (int k = 0; k < 8; k++) begin
         if (k % 2 == 0) begin
            io_cmd_ready = 1'b1;
            io_resp_v    = 1'b0;
            exp_rdy      = ((k / 2) % 2 == 0) ? 2'b01 : 2'b10;
            #1;
            checks++;
            if (cmd_ready !== exp_rdy || io_cmd !== (exp_rdy[0] ? msg0 : msg1)) begin
               errors++;
               $display("FAIL fair_grant k=%0d: cmd_ready=%b, want %b", k, cmd_ready, exp_rdy);
            end
            tick();
            checks++;
            if (outstanding !== 3'd1) begin
               errors++;
               $display("FAIL fair_cnt1 k=%0d: outstanding=%0d, want 1", k, outstanding);
            end
         end else begin
            io_cmd_ready = 1'b0;
            io_resp_v    = 1'b1;
            exp_rv       = ((k / 2) % 2 == 0) ? 2'b01 : 2'b10;
            #1;
            checks++;
            if (resp_v !== exp_rv || io_resp_yumi !== 1'b1) begin
               errors++;
               $display("FAIL fair_resp k=%0d: resp_v=%b yumi=%b, want %b/1", k, resp_v, io_resp_yumi, exp_rv);
            end
            tick();
            checks++;
            if (outstanding !== 3'd0) begin
               errors++;
               $display("FAIL fair_cnt0 k=%0d: outstanding=%0d, want 0", k, outstanding);
            end
         end
      end
   endtask

   task automatic test_lock();
      do_reset();
      cmd_v        = 2'b10;
      io_cmd_ready = 1'b0;
      for (int k = 0; k < 3; k++) begin
         if (k == 1) cmd_v = 2'b11;
         #1;
         checks++;
         if (io_cmd !== msg1 || io_cmd_v !== 1'b1 || cmd_ready !== 2'b00) begin
            errors++;
            $display("FAIL lock_hold k=%0d: io_cmd=%h v=%b rdy=%b, want req1 msg", k, io_cmd, io_cmd_v, cmd_ready);
         end
         tick();
      end
      io_cmd_ready = 1'b1;
      #1;
      checks++;
      if (cmd_ready !== 2'b10 || io_cmd !== msg1) begin
         errors++;
         $display("FAIL lock_first: cmd_ready=%b, want 10", cmd_ready);
      end
      tick();
      checks++;
      if (cmd_ready !== 2'b01 || io_cmd !== msg0) begin
         errors++;
         $display("FAIL lock_next: cmd_ready=%b, want 01", cmd_ready);
      end
      tick();
      checks++;
      if (outstanding !== 3'd2) begin
         errors++;
         $display("FAIL lock_cnt: outstanding=%0d, want 2", outstanding);
      end
   endtask

   task automatic test_credit();
      int hs;
      do_reset();
      cmd_v        = 2'b11;
      io_cmd_ready = 1'b1;
      hs = 0;
      for (int k = 0; k < 7; k++) begin
         #1;
         if (io_cmd_v && io_cmd_ready) hs++;
         tick();
      end
      checks++;
      if (hs != 4 || io_cmd_v !== 1'b0 || outstanding !== 3'd4) begin
         errors++;
         $display("FAIL credit_full: hs=%0d v=%b outstanding=%0d, want 4/0/4", hs, io_cmd_v, outstanding);
      end
      io_resp_v = 1'b1;
      resp_yumi = 2'b11;
      #1;
      checks++;
      if (io_cmd_v !== 1'b0 || cmd_ready !== 2'b00 || resp_v !== 2'b01) begin
         errors++;
         $display("FAIL credit_pop: v=%b rdy=%b resp_v=%b, want 0/00/01", io_cmd_v, cmd_ready, resp_v);
      end
      tick();
      io_resp_v = 1'b0;
      hs = 0;
      for (int k = 0; k < 4; k++) begin
         #1;
         if (io_cmd_v && io_cmd_ready) hs++;
         tick();
      end
      checks++;
      if (hs != 1 || outstanding !== 3'd4) begin
         errors++;
         $display("FAIL credit_refill: hs=%0d outstanding=%0d, want 1/4", hs, outstanding);
      end
   endtask

   task automatic test_routing();
      logic [1:0] seq [3];
      seq[0] = 2'b10;
      seq[1] = 2'b01;
      seq[2] = 2'b10;
      do_reset();
      io_cmd_ready = 1'b1;
      for (int k = 0; k < 3; k++) begin
         cmd_v = seq[k];
         tick();
      end
      cmd_v        = 2'b00;
      io_cmd_ready = 1'b0;
      io_resp      = rmsg;
      io_resp_v    = 1'b1;
      resp_yumi    = 2'b00;
      #1;
      checks++;
      if (resp_v !== 2'b10 || io_resp_yumi !== 1'b0 || resp !== rmsg) begin
         errors++;
         $display("FAIL route_stall: resp_v=%b yumi=%b, want 10/0", resp_v, io_resp_yumi);
      end
      tick();
      checks++;
      if (outstanding !== 3'd3) begin
         errors++;
         $display("FAIL route_cnt: outstanding=%0d, want 3", outstanding);
      end
      resp_yumi = 2'b11;
      for (int k = 0; k < 3; k++) begin
         #1;
         checks++;
         if (resp_v !== seq[k] || io_resp_yumi !== 1'b1) begin
            errors++;
            $display("FAIL route_seq k=%0d: resp_v=%b yumi=%b, want %b/1", k, resp_v, io_resp_yumi, seq[k]);
         end
         tick();
      end
      io_resp_v = 1'b0;
      checks++;
      if (outstanding !== 3'd0 || error !== 1'b0) begin
         errors++;
         $display("FAIL route_end: outstanding=%0d error=%b, want 0/0", outstanding, error);
      end
   endtask

   task automatic test_push_pop();
      do_reset();
      cmd_v        = 2'b11;
      io_cmd_ready = 1'b1;
      tick();
      tick();
      io_resp_v = 1'b1;
      resp_yumi = 2'b11;
      #1;
      checks++;
      if (resp_v !== 2'b01 || cmd_ready !== 2'b01 || outstanding !== 3'd2) begin
         errors++;
         $display("FAIL pp_same: resp_v=%b rdy=%b cnt=%0d, want 01/01/2", resp_v, cmd_ready, outstanding);
      end
      tick();
      cmd_v = 2'b00;
      checks++;
      if (outstanding !== 3'd2) begin
         errors++;
         $display("FAIL pp_cnt: outstanding=%0d, want 2", outstanding);
      end
      #1;
      checks++;
      if (resp_v !== 2'b10) begin
         errors++;
         $display("FAIL pp_order1: resp_v=%b, want 10", resp_v);
      end
      tick();
      checks++;
      if (resp_v !== 2'b01) begin
         errors++;
         $display("FAIL pp_order2: resp_v=%b, want 01", resp_v);
      end
      tick();
      io_resp_v = 1'b0;
      checks++;
      if (outstanding !== 3'd0) begin
         errors++;
         $display("FAIL pp_drain: outstanding=%0d, want 0", outstanding);
      end
   endtask

   task automatic test_error();
      do_reset();
      cmd_v        = 2'b01;
      io_cmd_ready = 1'b1;
      tick();
      idle_inputs();
      reset = 1'b1;
      #1;
      checks++;
      if (outstanding !== 3'd0 || io_cmd_v !== 1'b0) begin
         errors++;
         $display("FAIL err_midreset: outstanding=%0d v=%b, want 0/0", outstanding, io_cmd_v);
      end
      tick();
      reset     = 1'b0;
      io_resp_v = 1'b1;
      resp_yumi = 2'b11;
      #1;
      checks++;
      if (resp_v !== 2'b00 || io_resp_yumi !== 1'b0 || error !== 1'b0) begin
         errors++;
         $display("FAIL err_spur: resp_v=%b yumi=%b err=%b, want 00/0/0", resp_v, io_resp_yumi, error);
      end
      tick();
      io_resp_v = 1'b0;
      checks++;
      if (error !== 1'b1) begin
         errors++;
         $display("FAIL err_set: error=%b, want 1", error);
      end
      tick();
      tick();
      checks++;
      if (error !== 1'b1 || outstanding !== 3'd0) begin
         errors++;
         $display("FAIL err_sticky: error=%b cnt=%0d, want 1/0", error, outstanding);
      end
   endtask

   initial begin
      msg0    = {4{32'hAAAA_0000}};
      msg1    = {4{32'hBBBB_1111}};
      rmsg    = {4{32'hC0DE_5A5A}};
      cmd     = {msg1, msg0};
      io_resp = '0;
      reset   = 1'b1;
      idle_inputs();
      #2;
      test_reset();
      test_fairness();
      test_lock();
      test_credit();
      test_routing();
      test_push_pop();
      test_error();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/bp_io_cmd_arbiter.md
BP_IO_CMD_ARBITER -- requirements
Module: bp_io_cmd_arbiter

Interface
REQ-001 Parameter num_req_p, default 2: number of command requesters; SHALL be at least 2.
REQ-002 Parameter msg_width_p, default 128: width of one packed memory message (header plus data).
REQ-003 Parameter max_outstanding_p, default 4: maximum number of commands in flight without a response.
REQ-004 clk_i  in  1  single clock; all state SHALL update on its rising edge.
REQ-005 reset_i  in  1  reset; asynchronous, active-high.
REQ-006 cmd_i  in  num_req_p*msg_width_p  requester messages; requester i occupies slice i.
REQ-007 cmd_v_i  in  num_req_p  per-requester valid.
REQ-008 cmd_ready_o  out  num_req_p  per-requester ready (ready-and-valid handshake).
REQ-009 resp_o  out  msg_width_p  response message, broadcast to all requesters.
REQ-010 resp_v_o  out  num_req_p  per-requester response valid.
REQ-011 resp_yumi_i  in  num_req_p  per-requester response consume.
REQ-012 io_cmd_o  out  msg_width_p  arbitrated command to the serialized IO link.
REQ-013 io_cmd_v_o  out  1  command valid.
REQ-014 io_cmd_ready_i  in  1  link ready.
REQ-015 io_resp_i  in  msg_width_p  link response.
REQ-016 io_resp_v_i  in  1  link response valid.
REQ-017 io_resp_yumi_o  out  1  link response consume.
REQ-018 outstanding_o  out  clog2(max_outstanding_p+1)  count of in-flight commands.
REQ-019 error_o  out  1  sticky flag: a response arrived with no command outstanding.

Function
REQ-020 The block SHALL keep a round-robin pointer. The winner is the first valid requester found scanning upward from the pointer, wrapping modulo num_req_p.
REQ-021 A command SHALL be issuable only when outstanding_o < max_outstanding_p (credit available).
REQ-022 io_cmd_v_o SHALL equal (any cmd_v_i) AND credit available.
REQ-023 io_cmd_o SHALL be the winner's slice of cmd_i.
REQ-024 cmd_ready_o[i] SHALL equal io_cmd_ready_i AND credit available AND (i is the winner); at most one bit SHALL be set.
REQ-025 Grant lock: if io_cmd_v_o=1 and io_cmd_ready_i=0, the winner SHALL be registered. That requester SHALL remain the winner until the handshake completes, even if a higher-priority requester becomes valid. Requesters SHALL hold cmd_v_i and cmd_i stable while locked.
REQ-026 On each command handshake (io_cmd_v_o and io_cmd_ready_i), the block SHALL:
- set the pointer to (winner+1) mod num_req_p;
- clear the lock;
- push the winner ID into an in-order ID FIFO of depth max_outstanding_p.
REQ-027 Responses return in command order. The FIFO head ID SHALL route the response:
- resp_v_o[head] = io_resp_v_i; every other bit is 0;
- resp_o = io_resp_i.
REQ-028 io_resp_yumi_o SHALL equal resp_yumi_i[head] AND io_resp_v_i AND FIFO non-empty.
REQ-029 On io_resp_yumi_o=1 the FIFO SHALL pop.
REQ-030 outstanding_o update each cycle:
- push only: +1;
- pop only: -1;
- push and pop in the same cycle: unchanged.
outstanding_o SHALL never exceed max_outstanding_p nor underflow.
REQ-031 With credit zero (count = max), a pop in a cycle SHALL NOT enable a push in that same cycle; credit is evaluated on the registered count.
REQ-032 If io_resp_v_i=1 while the FIFO is empty: all resp_v_o and io_resp_yumi_o SHALL be 0, and error_o SHALL set and hold until reset.
REQ-033 The command path and response path SHALL carry zero-cycle latency (combinational pass-through). The block adds no bubble between back-to-back handshakes.

Reset
REQ-034 While reset_i=1, the block SHALL hold:
- pointer=0, lock cleared, FIFO empty, outstanding_o=0, error_o=0;
- io_cmd_v_o=0, all cmd_ready_o=0, resp_v_o=0, io_resp_yumi_o=0.
REQ-035 Reset asserted mid-transaction SHALL discard all in-flight IDs. Responses arriving after reset deassertion with an empty FIFO SHALL be treated per REQ-032.

Verification
REQ-036 Fairness: both requesters valid continuously, link always ready, responses returned immediately -> grants alternate 0,1,0,1; outstanding_o toggles between 0 and 1.
REQ-037 Lock: only req1 valid, io_cmd_ready_i=0 for 3 cycles, req0 raises valid in cycle 2 -> io_cmd_o stays req1's message; req1 handshakes first; req0 is granted next.
REQ-038 Credit: max_outstanding_p=4, no responses, both requesters valid -> exactly 4 handshakes; then io_cmd_v_o=0 and outstanding_o=4. One response yumi -> exactly one further handshake.
REQ-039 Routing: issue order req1, req0, req1; three responses -> resp_v_o sequence 2'b10, 2'b01, 2'b10. A response held with resp_yumi_i=0 stalls; io_resp_yumi_o stays 0.
REQ-040 Simultaneous push and pop at outstanding_o=2 -> outstanding_o stays 2, and the FIFO order is preserved.
REQ-041 Spurious response after reset -> error_o=1 and stays 1; no resp_v_o bit asserted; io_resp_yumi_o=0.
